matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Sequences one N x N matrix multiply C = A * B over three single-port memories (MEM_A, MEM_B, MEM_C).
//  Generates read addresses for A and B, valid/first strobes for the external MAC unit, and C write strobes.
//  Sits under the top-level controller, between its start/done handshake and the memories plus MAC datapath.
//  Carries no data. All sequencing outputs are registered.
// PARAMETERS
//  N      32   matrix dimension; power of two, 2..64
//  LOG2N  5    log2(N)
//  AW     12   memory address width; must satisfy AW >= 2*LOG2N
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous reset, active-high
//  start      in   1    pulse; begin one multiply (sampled only in IDLE)
//  busy       out  1    high from the cycle after start is accepted until done
//  done       out  1    one-cycle pulse when every C element has been written
//  a_en       out  1    MEM_A read enable
//  a_addr     out  AW   A element (i,k) = i*N+k, row-major
//  b_en       out  1    MEM_B read enable; always equals a_en
//  b_addr     out  AW   B element (k,j) = k*N+j, row-major
//  mac_en     out  1    A/B read data valid this cycle; MAC accumulates
//  mac_first  out  1    with mac_en: load product instead of add (k==0)
//  c_we       out  1    MEM_C write enable; MAC accumulator holds final sum
//  c_addr     out  AW   C element (i,j) = i*N+j
//  pause      in   1    only when SEQ_PAUSE_EN is defined
// BEHAVIOUR
//  Memories have 1-cycle read latency; the MAC register updates on the edge that ends a mac_en cycle.
//  Reset: state=IDLE; i, j, k=0; busy, done, a_en, b_en, mac_en, mac_first, c_we=0; all addresses=0.
//  Reset mid-operation aborts immediately; no further c_we is issued and memory contents are left as is.
//  FSM:
//   IDLE : start=1 -> RUN, clear i/j/k. start while not IDLE is ignored.
//   RUN  : issue one read per cycle (a_en=b_en=1); k increments fastest, then j, then i.
//          Issuing (N-1,N-1,N-1) -> DRAIN.
//   DRAIN: two cycles, no issue; in-flight pipeline empties -> DONE.
//   DONE : done=1 for one cycle, busy=0 -> IDLE. A start in this cycle is ignored.
//  Pipeline (stage registers, relative to issue cycle t):
//   t   : a_en, a_addr, b_addr
//   t+1 : mac_en, with mac_first = (k==0)
//   t+2 : c_we = 1 with c_addr = i*N+j, only if the issue at t had k==N-1
//  Timing: start sampled at edge 0 -> first issue at cycle 1; last issue at cycle N^3.
//   Last c_we at cycle N^3+2; done at cycle N^3+3.
//  Exactly N*N c_we pulses per run, in ascending c_addr order, never two in consecutive C-writes to the same addr.
//  Counter wrap: k==N-1 -> k=0, j++; j==N-1 -> j=0, i++. Counters never exceed N-1.
//  Address arithmetic: {i,k} / {k,j} / {i,j} concatenation, zero-extended to AW.
// CONFIGURATION
//  SEQ_PAUSE_EN defined:
//   - Adds input pause. pause=1 in RUN suppresses issue that cycle: a_en=0, counters hold.
//   - In-flight stages (mac_en, c_we) still complete.
//   - Done is delayed by exactly the number of RUN cycles with pause=1. pause is ignored outside RUN.
//  SEQ_PAUSE_EN undefined:
//   - No pause port; issue runs every RUN cycle; timing exactly as above.
// TESTING
//  1 N=2, A=[1 2;3 4], B=[5 6;7 8] -> MEM_C = {19,22,43,50}; done at cycle 11; exactly 4 c_we.
//  2 N=32 default, random 8-bit A/B vectors -> all 1024 C words match the golden file;
//    done exactly 32771 cycles after start; busy high for 32770 cycles.
//  3 start pulsed again at cycles 5 and 100 during RUN -> ignored; single done; counts unchanged.
//  4 rst at cycle 500 of a run -> next cycle all outputs 0, state IDLE;
//    new start -> full correct result, timing as in test 2.
//  5 N=2: check a_addr/b_addr sequence (0,0)(1,2)(0,1)(1,3)(2,0)(3,2)...;
//    mac_first high on cycles 2,4,6,8; c_addr 0,1,2,3.
//  6 SEQ_PAUSE_EN, N=2, pause=1 for cycles 3..5 -> results as in test 1; done at cycle 14.

Source files
------------

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//   Sequences one N x N matrix multiply C = A * B over three single-port
//   memories. It generates the A/B read addresses, the valid/first strobes for
//   the external MAC unit and the C write strobes. It carries no data.
//
//   The inner index k runs fastest, then j, then i. For each (i,j) the MAC sees
//   N products. The first product loads the accumulator and the remaining
//   products add to it. C(i,j) is written two cycles after its last issue.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; aborts a run immediately
//   pause      (SEQ_PAUSE_EN only) holds issue for one RUN cycle per cycle high
//   start      begin one multiply; only accepted in IDLE
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse after the last C write
//   a_en/b_en  MEM_A / MEM_B read enables (always equal)
//   a_addr     A(i,k) = {i,k}, zero-extended to AW
//   b_addr     B(k,j) = {k,j}, zero-extended to AW
//   mac_en     read data valid this cycle; the MAC accumulates
//   mac_first  with mac_en: load the product instead of adding it (k == 0)
//   c_we       MEM_C write enable; the accumulator holds the final sum
//   c_addr     C(i,j) = {i,j}, zero-extended to AW
//
// Configuration macro: SEQ_PAUSE_EN
//   When defined, the pause input is added. pause is sampled on an edge while
//   in RUN. A high sample suppresses the issue in the following cycle and the
//   counters hold. Every such cycle delays done by exactly one cycle. The
//   in-flight mac_en/c_we stages still complete.
// -----------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SEQ_PAUSE_EN
  input  logic          pause,
`endif
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          a_en,
  output logic [AW-1:0] a_addr,
  output logic          b_en,
  output logic [AW-1:0] b_addr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          c_we,
  output logic [AW-1:0] c_addr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] CNT_ONE = LOG2N'(1);

  // Places {hi,lo} in the low bits of an address and zero-fills the upper bits.
  function automatic logic [AW-1:0] addr_of(input logic [LOG2N-1:0] hi,
                                            input logic [LOG2N-1:0] lo);
    logic [AW-1:0] r;
    r = {AW{1'b0}};
    r[2*LOG2N-1:0] = {hi, lo};
    return r;
  endfunction

  logic pause_s;
`ifdef SEQ_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // i_r/j_r/k_r hold the position of the issue currently on a_addr when
  // a_en_r is high. When a_en_r is low (paused), they hold the next position.
  state_t            state_r, state_n;
  logic [LOG2N-1:0]  i_r, j_r, k_r;
  logic [LOG2N-1:0]  i_n, j_n, k_n;
  logic              all_issued_r, all_issued_n;
  logic              drain_cnt_r, drain_cnt_n;
  logic              issue_n;

  logic              busy_r, done_r, a_en_r, mac_en_r, mac_first_r, c_we_r;
  logic [AW-1:0]     a_addr_r, b_addr_r, c_addr_r;
  logic              s1_last_r;       // issue in the MAC stage had k == N-1
  logic [AW-1:0]     s1_cij_r;        // C address carried with that issue
  logic              c_we_n;

  logic              last_pos_s;
  logic              issue_fin_s;

  assign last_pos_s  = (i_r == CNT_MAX) && (j_r == CNT_MAX) && (k_r == CNT_MAX);
  assign issue_fin_s = a_en_r && last_pos_s;
  assign c_we_n      = mac_en_r && s1_last_r;

  // Next state, next counter position and the decision to issue next cycle.
  always_comb begin
    state_n      = state_r;
    i_n          = i_r;
    j_n          = j_r;
    k_n          = k_r;
    all_issued_n = all_issued_r;
    drain_cnt_n  = drain_cnt_r;
    issue_n      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n      = ST_RUN;
          i_n          = {LOG2N{1'b0}};
          j_n          = {LOG2N{1'b0}};
          k_n          = {LOG2N{1'b0}};
          all_issued_n = 1'b0;
          issue_n      = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Step past the issue made this cycle. The final position is not
        // wrapped, so the counters never exceed N-1.
        if (a_en_r && !last_pos_s) begin
          if (k_r == CNT_MAX) begin
            k_n = {LOG2N{1'b0}};
            if (j_r == CNT_MAX) begin
              j_n = {LOG2N{1'b0}};
              i_n = i_r + CNT_ONE;
            end else begin
              j_n = j_r + CNT_ONE;
            end
          end else begin
            k_n = k_r + CNT_ONE;
          end
        end else begin
          k_n = k_r;
        end
        if (issue_fin_s) begin
          all_issued_n = 1'b1;
        end else begin
          all_issued_n = all_issued_r;
        end
        // A paused RUN cycle always costs exactly one cycle, including one
        // that falls after the final issue.
        if (pause_s) begin
          issue_n = 1'b0;
        end else if (all_issued_r || issue_fin_s) begin
          state_n     = ST_DRAIN;
          drain_cnt_n = 1'b0;
        end else begin
          issue_n = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r) begin
          state_n = ST_DONE;
        end else begin
          drain_cnt_n = 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, counters and all registered sequencing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      i_r          <= {LOG2N{1'b0}};
      j_r          <= {LOG2N{1'b0}};
      k_r          <= {LOG2N{1'b0}};
      all_issued_r <= 1'b0;
      drain_cnt_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      a_en_r       <= 1'b0;
      a_addr_r     <= {AW{1'b0}};
      b_addr_r     <= {AW{1'b0}};
      mac_en_r     <= 1'b0;
      mac_first_r  <= 1'b0;
      s1_last_r    <= 1'b0;
      s1_cij_r     <= {AW{1'b0}};
      c_we_r       <= 1'b0;
      c_addr_r     <= {AW{1'b0}};
    end else begin
      state_r      <= state_n;
      i_r          <= i_n;
      j_r          <= j_n;
      k_r          <= k_n;
      all_issued_r <= all_issued_n;
      drain_cnt_r  <= drain_cnt_n;
      busy_r       <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done_r       <= (state_n == ST_DONE);
      // Issue stage
      a_en_r       <= issue_n;
      a_addr_r     <= issue_n ? addr_of(i_n, k_n) : {AW{1'b0}};
      b_addr_r     <= issue_n ? addr_of(k_n, j_n) : {AW{1'b0}};
      // MAC stage: read data from the issue stage arrives here
      mac_en_r     <= a_en_r;
      mac_first_r  <= a_en_r && (k_r == {LOG2N{1'b0}});
      s1_last_r    <= a_en_r && (k_r == CNT_MAX);
      s1_cij_r     <= addr_of(i_r, j_r);
      // Write stage: the accumulator now holds the finished dot product
      c_we_r       <= c_we_n;
      c_addr_r     <= c_we_n ? s1_cij_r : c_addr_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign a_en      = a_en_r;
  assign b_en      = a_en_r;
  assign a_addr    = a_addr_r;
  assign b_addr    = b_addr_r;
  assign mac_en    = mac_en_r;
  assign mac_first = mac_first_r;
  assign c_we      = c_we_r;
  assign c_addr    = c_addr_r;

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
//   Drives matmul_sequencer (N=4) with random 8-bit matrices. It models the
//   three memories (1-cycle read latency) and the MAC. The results are
//   compared with a plain triple-loop matrix product, and the address, strobe
//   and timing behaviour is compared with values derived from the loop order.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

  localparam int N     = 4;
  localparam int LOG2N = 2;
  localparam int AW    = 5;
  localparam int N3    = N * N * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
`ifdef SEQ_PAUSE_EN
  logic          pause = 1'b0;
`endif
  logic          busy, done, a_en, b_en, mac_en, mac_first, c_we;
  logic [AW-1:0] a_addr, b_addr, c_addr;

  matmul_sequencer #(.N(N), .LOG2N(LOG2N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_PAUSE_EN
    .pause     (pause),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .a_en      (a_en),
    .a_addr    (a_addr),
    .b_en      (b_en),
    .b_addr    (b_addr),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .c_we      (c_we),
    .c_addr    (c_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memories and run records
  int unsigned mem_a [2**AW];
  int unsigned mem_b [2**AW];
  int unsigned mem_c [2**AW];
  int unsigned pa, pb, acc;
  logic [2*AW-1:0] iq[$];
  logic [AW-1:0]   cq[$];
  int busy_cnt, done_cnt, done_cyc, mf_cnt, ben_bad;
  int ecount = 0;
  int t0 = 0;

  always @(posedge clk) ecount <= ecount + 1;

  // Memory + MAC model, sampled mid-cycle
  always @(negedge clk) begin
    if (c_we === 1'b1) begin
      mem_c[c_addr] = acc;
      cq.push_back(c_addr);
    end
    if (mac_en === 1'b1) begin
      if (mac_first === 1'b1) begin
        acc = pa * pb;
        mf_cnt++;
      end else begin
        acc = acc + pa * pb;
      end
    end
    if (a_en === 1'b1) begin
      pa = mem_a[a_addr];
      pb = mem_b[b_addr];
      iq.push_back({a_addr, b_addr});
    end
    if (b_en !== a_en) ben_bad++;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = ecount - t0 + 1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_run();
    iq.delete();
    cq.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; mf_cnt = 0; ben_bad = 0;
    for (int n = 0; n < 2**AW; n++) begin
      mem_a[n] = $urandom_range(0, 255);
      mem_b[n] = $urandom_range(0, 255);
      mem_c[n] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = ecount;
  endtask

  task automatic wait_cycle(input int c);
    while ((ecount - t0 + 1) < c) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_run(input int np);
    int guard;
    longint obs;
    int unsigned sum;
    guard = 0;
    while (done_cnt == 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    chk("done_cycle", done_cyc, N3 + 3 + np);
    chk("done_count", done_cnt, 1);
    chk("busy_cycles", busy_cnt, N3 + 2 + np);
    chk("b_en_eq_a_en", ben_bad, 0);
    chk("mac_first_count", mf_cnt, N * N);
    chk("issue_count", iq.size(), N3);
    chk("c_we_count", cq.size(), N * N);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (i * N + j) * N + k;
          obs = (idx < iq.size()) ? longint'(iq[idx]) : -1;
          chk("issue_addr", obs, longint'((i * N + k) * (2**AW) + (k * N + j)));
        end
    for (int n = 0; n < N * N; n++) begin
      obs = (n < cq.size()) ? longint'(cq[n]) : -1;
      chk("c_addr_order", obs, n);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += mem_a[i * N + k] * mem_b[k * N + j];
        chk("c_value", mem_c[i * N + j], sum);
      end
  endtask

  initial begin
    int np;
    int cw;
    np = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", longint'({busy, done, a_en, b_en, mac_en, mac_first, c_we}), 0);
    chk("reset_addrs", longint'({a_addr, b_addr, c_addr}), 0);
    rst = 1'b0;

    // run 1: plain multiply (paused for three RUN cycles when enabled)
    clear_run();
    start_run();
    chk("first_issue_a_en", a_en, 1);
`ifdef SEQ_PAUSE_EN
    wait_cycle(3);
    pause = 1'b1;
    wait_cycle(6);
    pause = 1'b0;
    np = 3;
`endif
    check_run(np);

    // run 2: start pulses during RUN and on the DONE cycle are ignored
    clear_run();
    start_run();
    wait_cycle(5);
    pulse_start();
    wait_cycle(40);
    pulse_start();
    wait_cycle(N3 + 3);
    pulse_start();
    check_run(0);
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_a_en", a_en, 0);

    // run 3: reset mid-run aborts, then a fresh run completes correctly
    clear_run();
    start_run();
    wait_cycle(30);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", longint'({busy, done, a_en, b_en, mac_en, mac_first, c_we}), 0);
    chk("abort_addrs", longint'({a_addr, b_addr, c_addr}), 0);
    cw = cq.size();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_more_c_we", cq.size(), cw);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_stays_idle", busy, 0);
    clear_run();
    start_run();
    check_run(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
